bch_error_correct_buf: RTL and testbench

Downstream stage of the BCH Chien-search error locator. It buffers received data beats while syndrome, key-equation and error-search stages run. It pops one buffered beat for every `err` beat the locator presents and emits the corrected data, `data ^ err`, with codeword framing and a per-codeword corrected-bit count. It is the last datapath stage before the decoder output.

---
 rtl/bch_error_correct_buf_if.sv | 34 +++
 rtl/bch_error_correct_buf.sv | 114 +++++++++++
 tb/tb_bch_error_correct_buf.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/bch_error_correct_buf_if.sv
// Handshake bundle between the Chien-search locator, the data source and the
// correction buffer. The slave modport is the buffer's view.
interface bch_error_correct_buf_if #(
    parameter int DATA_BITS = 5,
    parameter int BITS      = 1
);
    localparam int ECW = $clog2(DATA_BITS + 1);

    logic [BITS-1:0] data_in;
    logic            data_valid;
    logic            in_ready;
    logic [BITS-1:0] err;
    logic            err_valid;
    logic            err_first;
    logic [BITS-1:0] data_out;
    logic            out_valid;
    logic            out_first;
    logic            out_last;
    logic [ECW-1:0]  err_count;
    logic            overflow;
    logic            underflow;

    modport master (
        output data_in, data_valid, err, err_valid, err_first,
        input  in_ready, data_out, out_valid, out_first, out_last,
               err_count, overflow, underflow
    );

    modport slave (
        input  data_in, data_valid, err, err_valid, err_first,
        output in_ready, data_out, out_valid, out_first, out_last,
               err_count, overflow, underflow
    );
endinterface

// File: rtl/bch_error_correct_buf.sv
// Buffers received beats until the error locator catches up, then emits
// data ^ err with codeword framing and a per-codeword corrected-bit count.
module bch_error_correct_buf #(
    parameter int DATA_BITS = 5,
    parameter int BITS      = 1,
    parameter int NWORDS    = 2
) (
    input logic                clk,
    input logic                rst_n,
    bch_error_correct_buf_if.slave bus
);
    localparam int W      = (DATA_BITS + BITS - 1) / BITS;
    localparam int D      = NWORDS * W;
    localparam int R      = DATA_BITS % BITS;
    localparam int CNT_W  = $clog2(D + 1);
    localparam int PTR_W  = (D > 1) ? $clog2(D) : 1;
    localparam int BEAT_W = (W > 1) ? $clog2(W) : 1;
    localparam int ECW    = $clog2(DATA_BITS + 1);
    // Only the low R bits of the final beat carry codeword data.
    localparam logic [BITS-1:0] LAST_MASK =
        (R == 0) ? {BITS{1'b1}} : ({BITS{1'b1}} >> (BITS - R));

    logic [BITS-1:0]   mem [D];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [BEAT_W-1:0] beat, cur_beat;
    logic [ECW-1:0]    acc, pc, acc_next;
    logic [BITS-1:0]   masked_err;
    logic              in_ready, push, pop, is_first, is_last;

    logic [BITS-1:0]   data_out_q;
    logic              out_valid_q, out_first_q, out_last_q;
    logic [ECW-1:0]    err_count_q;
    logic              overflow_q, underflow_q;

    assign in_ready = (count != CNT_W'(D));
    assign push     = bus.data_valid && in_ready;
    assign pop      = bus.err_valid && (count != '0);

    always_comb begin
        cur_beat   = bus.err_first ? '0 : beat;
        is_first   = (cur_beat == '0);
        is_last    = (cur_beat == BEAT_W'(W - 1));
        masked_err = is_last ? (bus.err & LAST_MASK) : bus.err;
        pc         = '0;
        for (int i = 0; i < BITS; i++) begin
            pc = pc + ECW'(masked_err[i]);
        end
        acc_next = is_first ? pc : acc + pc;
    end

    // NOTE: the storage array carries no reset; stale entries are never read
    // because count gates every pop, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            beat        <= '0;
            acc         <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_count_q <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(D - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(D - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (bus.data_valid && !in_ready) overflow_q  <= 1'b1;
            if (bus.err_valid && count == '0) underflow_q <= 1'b1;

            out_valid_q <= pop;
            out_first_q <= pop && is_first;
            out_last_q  <= pop && is_last;
            if (pop) begin
                data_out_q <= mem[rd_ptr] ^ masked_err;
                acc        <= acc_next;
                beat       <= is_last ? '0 : cur_beat + BEAT_W'(1);
                if (is_last) begin
                    err_count_q <= acc_next;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.data_out  = data_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;
    assign bus.err_count = err_count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_bch_error_correct_buf.sv
// Scoreboard bench for bch_error_correct_buf: a queue-based codeword model
// predicts every output beat; a negedge monitor compares what the DUT emits.
module tb_bch_error_correct_buf;
    localparam int DATA_BITS = 5;
    localparam int BITS      = 2;
    localparam int NWORDS    = 2;
    localparam int W         = (DATA_BITS + BITS - 1) / BITS;
    localparam int D         = NWORDS * W;
    localparam int R         = DATA_BITS % BITS;

    typedef struct {
        logic [BITS-1:0] data;
        bit              first;
        bit              last;
        int              cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    bch_error_correct_buf_if #(.DATA_BITS(DATA_BITS), .BITS(BITS)) ifc ();

    bch_error_correct_buf #(
        .DATA_BITS(DATA_BITS), .BITS(BITS), .NWORDS(NWORDS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    logic [BITS-1:0] m_q[$];
    exp_t            exp_q[$];
    int              m_idx = 0;
    int              m_acc = 0;
    bit              m_ovf = 1'b0;
    bit              m_udf = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus; the model advances with the same edge.
    task automatic cycle(bit dv, logic [BITS-1:0] din, bit ev,
                         logic [BITS-1:0] e, bit ef);
        bit              rdy, can_pop;
        int              idx, pcnt;
        logic [BITS-1:0] me;
        exp_t            item;
        ifc.data_valid = dv;
        ifc.data_in    = din;
        ifc.err_valid  = ev;
        ifc.err        = e;
        ifc.err_first  = ef;
        rdy     = (m_q.size() != D);
        can_pop = (m_q.size() != 0);
        @(posedge clk);
        if (ev && can_pop) begin
            idx  = ef ? 0 : m_idx;
            me   = (idx == W - 1 && R != 0) ? BITS'(int'(e) % (1 << R)) : e;
            pcnt = $countones(me);
            m_acc = (idx == 0) ? pcnt : m_acc + pcnt;
            item.data  = m_q.pop_front() ^ me;
            item.first = (idx == 0);
            item.last  = (idx == W - 1);
            item.cnt   = m_acc;
            exp_q.push_back(item);
            m_idx = (idx + 1) % W;
        end else if (ev) begin
            m_udf = 1'b1;
        end
        if (dv && rdy) m_q.push_back(din);
        else if (dv)   m_ovf = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        ifc.data_valid = 1'b1;
        ifc.data_in    = BITS'($urandom);
        ifc.err_valid  = 1'b1;
        ifc.err        = BITS'($urandom);
        ifc.err_first  = 1'b0;
        @(posedge clk);
        #1;
        m_q.delete();
        exp_q.delete();
        m_idx = 0;
        m_acc = 0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        rst_n          = 1'b1;
        ifc.data_valid = 1'b0;
        ifc.err_valid  = 1'b0;
        check("rst in_ready",  ifc.in_ready,  1);
        check("rst out_valid", ifc.out_valid, 0);
        check("rst out_first", ifc.out_first, 0);
        check("rst out_last",  ifc.out_last,  0);
        check("rst data_out",  ifc.data_out,  0);
        check("rst err_count", ifc.err_count, 0);
        check("rst overflow",  ifc.overflow,  0);
        check("rst underflow", ifc.underflow, 0);
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t it;
        if (mon_en) begin
            check("in_ready",  ifc.in_ready,  m_q.size() != D);
            check("overflow",  ifc.overflow,  m_ovf);
            check("underflow", ifc.underflow, m_udf);
            if (ifc.out_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected out_valid: got 1, want 0 at %0t", $time);
                end else begin
                    it = exp_q.pop_front();
                    check("data_out",  ifc.data_out,  it.data);
                    check("out_first", ifc.out_first, it.first);
                    check("out_last",  ifc.out_last,  it.last);
                    if (it.last) check("err_count", ifc.err_count, it.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [BITS-1:0] dat [3] = '{2'b11, 2'b00, 2'b11};
        logic [BITS-1:0] ers [3] = '{2'b01, 2'b10, 2'b11};
        ifc.data_valid = 1'b0;
        ifc.data_in    = '0;
        ifc.err_valid  = 1'b0;
        ifc.err        = '0;
        ifc.err_first  = 1'b0;
        @(negedge clk);
        do_reset();

        // Partial last beat: expected output 10,10,10 with err_count 3.
        for (int i = 0; i < 3; i++) cycle(1, dat[i], 0, '0, 0);
        for (int i = 0; i < 3; i++) cycle(0, '0, 1, ers[i], i == 0);
        cycle(0, '0, 0, '0, 0);

        // Fill past capacity, then push and pop together while full.
        for (int i = 0; i <= D; i++) cycle(1, BITS'($urandom), 0, '0, 0);
        for (int i = 0; i < 5; i++) cycle(1, BITS'($urandom), 1, BITS'($urandom), 0);
        for (int i = 0; i < D; i++) cycle(0, '0, 1, BITS'($urandom), 0);
        cycle(0, '0, 0, '0, 0);

        // Underflow on empty, then resynchronise on index 2.
        cycle(0, '0, 1, 2'b11, 0);
        for (int i = 0; i < 5; i++) cycle(1, BITS'($urandom), 0, '0, 0);
        cycle(0, '0, 1, BITS'($urandom), 1);
        cycle(0, '0, 1, BITS'($urandom), 0);
        cycle(0, '0, 1, BITS'($urandom), 1);
        cycle(0, '0, 1, BITS'($urandom), 0);
        cycle(0, '0, 1, BITS'($urandom), 0);
        cycle(0, '0, 0, '0, 0);

        // Random mixed traffic with occasional resync.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 55, BITS'($urandom),
                  $urandom_range(0, 99) < 50, BITS'($urandom),
                  $urandom_range(0, 99) < 8);
        end

        // Reset mid-codeword, then a pop with nothing pushed.
        do_reset();
        for (int i = 0; i < 7; i++) cycle(1, BITS'($urandom), 0, '0, 0);
        cycle(0, '0, 1, BITS'($urandom), 1);
        cycle(0, '0, 1, BITS'($urandom), 0);
        do_reset();
        cycle(0, '0, 1, BITS'($urandom), 0);
        cycle(0, '0, 0, '0, 0);
        check("post-reset underflow", ifc.underflow, 1);

        repeat (3) cycle(0, '0, 0, '0, 0);
        check("scoreboard drained", exp_q.size(), 0);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
